mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit implementing the RV32M instructions, parametrised in data width. It sits in the execute stage beside the single-cycle integer ALU. Decode routes opcode 0110011 / func7 0000001 here instead of to the ALU. It accepts one operation through a valid/ready handshake, computes over multiple cycles, and holds the result until writeback accepts it.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width; must be ≥ 4 and even.
- `XREG_ADDRWIDTH`, default 5: register address width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `valid_in`  in  1  operation request.
- `ready_out`  out  1  unit can accept; high only in IDLE.
- `func3_in`  in  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_in`  in  XLEN  operand 1.
- `rs2_in`  in  XLEN  operand 2.
- `rd_addr_in`  in  XREG_ADDRWIDTH  destination register.
- `flush_in`  in  1  pipeline flush; abandon any operation.
- `valid_out`  out  1  result available.
- `ready_in`  in  1  writeback consumes result.
- `rd_out`  out  XLEN  result.
- `rd_addr_out`  out  XREG_ADDRWIDTH  destination register of the result.
- `busy_out`  out  1  state ≠ IDLE.

## Operation
- **Accept:** an operation is accepted on a rising edge with `valid_in & ready_out & ~flush_in`. At acceptance the unit latches `func3`, `rd_addr`, operand magnitudes and result-sign flags.
- **Signedness:**
  - rs1 is signed for MULH, MULHSU, DIV, REM.
  - rs2 is signed for MULH, DIV, REM.
  - All other operands are unsigned.
- **States:** IDLE → CALC → FIX → DONE → IDLE.
  - IDLE: on accept → CALC; if a special case applies → DONE directly.
  - CALC: runs exactly XLEN cycles, with a counter loaded with XLEN-1 and decremented to 0.
    - Multiply: shift-add on magnitudes into a 2·XLEN product register.
    - Divide: restoring radix-2, 1 quotient bit per cycle, (XLEN+1)-bit partial remainder.
  - FIX: one cycle. Applies two's-complement negation where required and selects the result:
    - MUL: low XLEN bits of the product.
    - MULH*: high XLEN bits of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - DONE: `valid_out`=1 with `rd_out`/`rd_addr_out` stable; → IDLE when `ready_in`=1.
- **Result sign rules:**
  - Product sign = sign(rs1) XOR sign(rs2), counting only operands treated as signed.
  - Quotient is negated when the signed operands differ in sign.
  - Remainder takes the sign of the dividend.
- **Special cases:** detected at acceptance; CALC and FIX are skipped.
  - Divisor = 0: DIV/DIVU result is all ones; REM/REMU result is rs1.
  - Signed overflow (rs1 = most-negative, rs2 = −1, DIV/REM only): DIV result is rs1; REM result is 0.
- **Flush:** `flush_in`=1 forces IDLE on the next edge from any state.
  - `valid_out` drops on that edge.
  - Flush takes priority over `valid_in` and `ready_in` in the same cycle.
- **Reset values:**
  - State IDLE, `valid_out`=0, `rd_out`=0, `rd_addr_out`=0, counter=0.
  - Hence `ready_out`=1 and `busy_out`=0 during and after reset.
- **Reset mid-operation:** state is discarded; no result is produced.

## Timing
- `ready_out` and `busy_out` are decoded from the state register only; they have no combinational path from inputs.
- Normal latency: `valid_out` rises XLEN+2 edges after the accepting edge (34 for XLEN=32).
- Special-case latency: `valid_out` rises 1 edge after the accepting edge.
- `valid_out` remains high and outputs remain stable until the edge where `ready_in`=1 or `flush_in`=1.
- Back-to-back operations leave at least one IDLE cycle between them.
  - Throughput is one operation per XLEN+3 cycles with `ready_in` tied high.
- Operand inputs are sampled only at acceptance; changes afterwards have no effect.

## Test plan
- MUL 7 × 0xFFFFFFFD → `rd_out` = 0xFFFFFFEB. `valid_out` rises 34 edges after accept, with `rd_addr_out` = accepted rd.
- MULH, MULHSU and MULHU on operands 0x80000000, 0x80000000:
  - MULH → 0x40000000.
  - MULHSU → 0xC0000000.
  - MULHU → 0x40000000.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF, and REM 5 / 0 → 5, each one edge after accept. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM of the same operands → 0.
- Hold `ready_in`=0 for 10 cycles in DONE → `valid_out` and `rd_out` stay stable and `ready_out` stays 0. A new `valid_in` during that time is not accepted.
- Assert `flush_in` at CALC cycle 10 → IDLE next edge with `ready_out`=1 and no `valid_out`. Separately, assert `rst_n`=0 mid-CALC → all outputs go to reset values immediately (asynchronously).

Source files
------------

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/result handshake bundle between execute-stage control and the mdu
interface mdu_iter_if #(
   parameter int XLEN           = 32,
   parameter int XREG_ADDRWIDTH = 5
);
   logic                      valid_in;
   logic                      ready_out;
   logic [2:0]                func3_in;
   logic [XLEN-1:0]           rs1_in;
   logic [XLEN-1:0]           rs2_in;
   logic [XREG_ADDRWIDTH-1:0] rd_addr_in;
   logic                      flush_in;
   logic                      valid_out;
   logic                      ready_in;
   logic [XLEN-1:0]           rd_out;
   logic [XREG_ADDRWIDTH-1:0] rd_addr_out;
   logic                      busy_out;
   modport master (
      output valid_in, func3_in, rs1_in, rs2_in, rd_addr_in, flush_in, ready_in,
      input  ready_out, valid_out, rd_out, rd_addr_out, busy_out
   );
   modport slave (
      input  valid_in, func3_in, rs1_in, rs2_in, rd_addr_in, flush_in, ready_in,
      output ready_out, valid_out, rd_out, rd_addr_out, busy_out
   );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module mdu_iter #(
   parameter int XLEN           = 32,
   parameter int XREG_ADDRWIDTH = 5
) (
   input logic         clk,
   input logic         rst_n,
   mdu_iter_if.slave   bus
);
   localparam int CW = $clog2(XLEN);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]                state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [2:0]                func3_q, func3_d;
   logic [XREG_ADDRWIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [XLEN-1:0]           b_q, b_d, rd_q, rd_d;
   logic [2*XLEN-1:0]         prod_q, prod_d;
   logic [XLEN:0]             rem_q, rem_d;
   logic                      neg_q, neg_d, rneg_q, rneg_d, valid_q, valid_d;

   logic                      accept, s1, s2, a_neg, b_neg, div0, ovf, special, ge;
   logic [XLEN-1:0]           a_mag, b_mag, spec_res, rem_fix, res;
   logic [XLEN:0]             msum, sub;
   logic [XLEN+1:0]           shifted;
   logic [2*XLEN-1:0]         prod_fix;

   assign bus.ready_out   = state_q == IDLE;
   assign bus.busy_out    = state_q != IDLE;
   assign bus.valid_out   = valid_q;
   assign bus.rd_out      = rd_q;
   assign bus.rd_addr_out = rd_addr_q;

   assign accept   = bus.valid_in & (state_q == IDLE) & ~bus.flush_in;
   assign s1       = (~bus.func3_in[2] & (bus.func3_in[1] ^ bus.func3_in[0])) | (bus.func3_in[2] & ~bus.func3_in[0]);
   assign s2       = (bus.func3_in == 3'b001) | (bus.func3_in[2] & ~bus.func3_in[0]);
   assign a_neg    = s1 & bus.rs1_in[XLEN-1];
   assign b_neg    = s2 & bus.rs2_in[XLEN-1];
   assign a_mag    = a_neg ? -bus.rs1_in : bus.rs1_in;
   assign b_mag    = b_neg ? -bus.rs2_in : bus.rs2_in;
   assign div0     = bus.func3_in[2] & (bus.rs2_in == '0);
   assign ovf      = bus.func3_in[2] & ~bus.func3_in[0] & (bus.rs1_in == MIN_NEG) & (bus.rs2_in == '1);
   assign special  = div0 | ovf;
   assign spec_res = div0 ? (bus.func3_in[1] ? bus.rs1_in : '1) : (bus.func3_in[1] ? '0 : bus.rs1_in);

   // multiply: conditional add into the high half, then shift the whole product right
   assign msum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
   // divide: dividend/quotient share the product low half, remainder gets the next dividend bit
   assign shifted  = {rem_q, prod_q[XLEN-1]};
   assign ge       = shifted >= {2'b00, b_q};
   assign sub      = shifted[XLEN:0] - {1'b0, b_q};

   assign prod_fix = neg_q ? -prod_q : prod_q;
   assign rem_fix  = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
   assign res      = func3_q[2] ? (func3_q[1] ? rem_fix : prod_fix[XLEN-1:0])
                               : ((func3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      func3_d   = func3_q;
      rd_addr_d = rd_addr_q;
      b_d       = b_q;
      rd_d      = rd_q;
      prod_d    = prod_q;
      rem_d     = rem_q;
      neg_d     = neg_q;
      rneg_d    = rneg_q;
      valid_d   = valid_q;
      case (state_q)
         IDLE: if (accept) begin
            func3_d   = bus.func3_in;
            rd_addr_d = bus.rd_addr_in;
            b_d       = b_mag;
            prod_d    = {{XLEN{1'b0}}, a_mag};
            rem_d     = '0;
            neg_d     = a_neg ^ b_neg;
            rneg_d    = a_neg;
            cnt_d     = CW'(XLEN-1);
            state_d   = special ? DONE : CALC;
            valid_d   = special;
            rd_d      = special ? spec_res : rd_q;
         end
         CALC: begin
            prod_d  = func3_q[2] ? {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], ge} : {msum, prod_q[XLEN-1:1]};
            rem_d   = func3_q[2] ? (ge ? sub : shifted[XLEN:0]) : rem_q;
            state_d = (cnt_q == '0) ? FIX : CALC;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
         end
         FIX: begin
            rd_d    = res;
            valid_d = 1'b1;
            state_d = DONE;
         end
         default: if (bus.ready_in) begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
      if (bus.flush_in) begin
         state_d = IDLE;
         valid_d = 1'b0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         func3_q   <= '0;
         rd_addr_q <= '0;
         b_q       <= '0;
         rd_q      <= '0;
         prod_q    <= '0;
         rem_q     <= '0;
         neg_q     <= 1'b0;
         rneg_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         func3_q   <= func3_d;
         rd_addr_q <= rd_addr_d;
         b_q       <= b_d;
         rd_q      <= rd_d;
         prod_q    <= prod_d;
         rem_q     <= rem_d;
         neg_q     <= neg_d;
         rneg_q    <= rneg_d;
         valid_q   <= valid_d;
      end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: vector table, randomized ops against an arithmetic model, and handshake/flush/reset sequences
module tb_mdu_iter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mdu_iter_if #(.XLEN(32), .XREG_ADDRWIDTH(5)) bus ();
   mdu_iter #(.XLEN(32), .XREG_ADDRWIDTH(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'b0, a});
      longint ub = longint'({32'b0, b});
      logic [63:0] p;
      case (f3)
         3'd0: begin p = 64'(ua * ub); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && b == 0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 34;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      @(negedge clk);
      bus.valid_in   = 1'b1;
      bus.func3_in   = f3;
      bus.rs1_in     = a;
      bus.rs2_in     = b;
      bus.rd_addr_in = rd;
      @(posedge clk); #1;
      bus.valid_in   = 1'b0;
      bus.func3_in   = 3'($urandom);
      bus.rs1_in     = $urandom;
      bus.rs2_in     = $urandom;
      bus.rd_addr_in = 5'($urandom);
   endtask

   // lat counts edges with the accepting edge as 1; a normal op therefore reports 34
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output logic [31:0] res, output logic [4:0] ra, output int lat);
      start_op(f3, a, b, rd);
      lat = 1;
      while (!bus.valid_out && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = bus.rd_out;
      ra  = bus.rd_addr_out;
      @(negedge clk);
      bus.ready_in = 1'b1;
      @(posedge clk); #1;
      bus.ready_in = 1'b0;
   endtask

   vec_t        vt[16];
   logic [31:0] res, hold_val;
   logic [4:0]  ra, rd;
   int          lat;
   logic        seen;

   initial begin
      vt[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34};
      vt[1]  = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 34};
      vt[2]  = '{3'd2, 32'h80000000,   32'h80000000, 32'hC0000000, 34};
      vt[3]  = '{3'd3, 32'h80000000,   32'h80000000, 32'h40000000, 34};
      vt[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34};
      vt[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34};
      vt[6]  = '{3'd5, 32'd100,        32'd7,        32'd14,       34};
      vt[7]  = '{3'd7, 32'd100,        32'd7,        32'd2,        34};
      vt[8]  = '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
      vt[9]  = '{3'd6, 32'd5,          32'd0,        32'd5,        1};
      vt[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
      vt[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
      vt[12] = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34};
      vt[13] = '{3'd4, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 34};
      vt[14] = '{3'd6, 32'd7,          32'hFFFFFFFE, 32'd1,        34};
      vt[15] = '{3'd5, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 34};

      bus.valid_in = 1'b0; bus.func3_in = '0; bus.rs1_in = '0; bus.rs2_in = '0;
      bus.rd_addr_in = '0; bus.flush_in = 1'b0; bus.ready_in = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset ready_out", 32'(bus.ready_out), 32'd1);
      check("reset busy_out", 32'(bus.busy_out), 32'd0);
      check("reset valid_out", 32'(bus.valid_out), 32'd0);
      check("reset rd_out", bus.rd_out, 32'd0);
      check("reset rd_addr_out", 32'(bus.rd_addr_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         rd = 5'($urandom_range(1, 31));
         run_op(vt[i].f3, vt[i].a, vt[i].b, rd, res, ra, lat);
         check($sformatf("vec%0d result", i), res, vt[i].exp);
         check($sformatf("vec%0d rd_addr", i), 32'(ra), 32'(rd));
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
      end

      for (int i = 0; i < 200; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         f3 = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         rd = 5'($urandom);
         run_op(f3, a, b, rd, res, ra, lat);
         check($sformatf("rand%0d f3=%0d a=%h b=%h result", i, f3, a, b), res, model(f3, a, b));
         check($sformatf("rand%0d rd_addr", i), 32'(ra), 32'(rd));
         check($sformatf("rand%0d latency", i), 32'(lat), 32'(model_lat(f3, a, b)));
      end

      // DONE held off by writeback while a new request is offered
      start_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd9);
      lat = 1;
      while (!bus.valid_out && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("hold reach done", 32'(bus.valid_out), 32'd1);
      hold_val = 32'hFFFFFFEB;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.valid_in = 1'b1; bus.func3_in = 3'd5; bus.rs1_in = 32'd9; bus.rs2_in = 32'd0;
         @(posedge clk); #1;
         check("hold valid_out", 32'(bus.valid_out), 32'd1);
         check("hold rd_out", bus.rd_out, hold_val);
         check("hold ready_out", 32'(bus.ready_out), 32'd0);
      end
      @(negedge clk);
      bus.valid_in = 1'b0; bus.ready_in = 1'b1;
      @(posedge clk); #1;
      bus.ready_in = 1'b0;
      check("hold release valid_out", 32'(bus.valid_out), 32'd0);
      check("hold release ready_out", 32'(bus.ready_out), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("hold no stray accept", 32'(bus.busy_out), 32'd0);

      // flush on the 10th CALC cycle
      start_op(3'd4, 32'd1000, 32'd3, 5'd4);
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("flush busy in calc", 32'(bus.busy_out), 32'd1);
      bus.flush_in = 1'b1;
      @(posedge clk); #1;
      bus.flush_in = 1'b0;
      check("flush ready_out", 32'(bus.ready_out), 32'd1);
      check("flush valid_out", 32'(bus.valid_out), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen |= bus.valid_out;
      end
      check("flush no late result", 32'(seen), 32'd0);

      // flush in DONE drops the result; flush beats a simultaneous request
      start_op(3'd5, 32'd5, 32'd0, 5'd3);
      check("flushdone valid before", 32'(bus.valid_out), 32'd1);
      @(negedge clk);
      bus.flush_in = 1'b1;
      @(posedge clk); #1;
      check("flushdone valid_out", 32'(bus.valid_out), 32'd0);
      check("flushdone ready_out", 32'(bus.ready_out), 32'd1);
      @(negedge clk);
      bus.valid_in = 1'b1; bus.func3_in = 3'd0; bus.rs1_in = 32'd3; bus.rs2_in = 32'd3;
      @(posedge clk); #1;
      check("flush over valid_in", 32'(bus.busy_out), 32'd0);
      @(negedge clk);
      bus.valid_in = 1'b0; bus.flush_in = 1'b0;

      // asynchronous reset mid-CALC after a result has left nonzero outputs
      run_op(3'd5, 32'd100, 32'd7, 5'd17, res, ra, lat);
      start_op(3'd4, 32'd12345, 32'd11, 5'd21);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("areset ready_out", 32'(bus.ready_out), 32'd1);
      check("areset busy_out", 32'(bus.busy_out), 32'd0);
      check("areset valid_out", 32'(bus.valid_out), 32'd0);
      check("areset rd_out", bus.rd_out, 32'd0);
      check("areset rd_addr_out", 32'(bus.rd_addr_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen |= bus.valid_out | bus.busy_out;
      end
      check("areset no result", 32'(seen), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
